// File: rtl/axi_uart_regs.sv
// rtl/axi_uart_regs.sv - AXI4-Lite register front end for the UART byte core with TX/RX FIFOs
// Define AXI_UART_IRQ_EN to build the level interrupt and the CTRL enable bits.
module axi_uart_regs #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [3:0]  s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [3:0]  s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [7:0]  data_send,
  output logic        ena_tx,
  input  logic        tx_done,
  input  logic [7:0]  data_recv,
  input  logic        new_rx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {T_IDLE, T_SEND} tx_state_t;

  logic [7:0]  r_tx_mem [FIFO_DEPTH];
  logic [7:0]  r_rx_mem [FIFO_DEPTH];
  logic [AW:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic        r_bvalid, r_rvalid, r_overrun;
  logic [1:0]  r_bresp;
  logic [31:0] r_rdata;
  logic [7:0]  r_data_send;
  logic        r_ena_tx, r_tx_done_q, r_new_rx_q;
  tx_state_t   r_tx_state, w_tx_state_nx;
  logic [7:0]  w_data_send_nx;
  logic        w_ena_tx_nx, w_tx_pop;
  logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_busy;
  logic        w_wr_fire, w_wr_tx, w_tx_push, w_wr_ctrl, w_ovr_clr;
  logic        w_rd_fire, w_rx_pop, w_rx_rise, w_rx_push, w_tx_done_rise;
  logic [31:0] w_rdata_nx;
  logic [1:0]  w_ctrl;
  logic        w_unused;

  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[AW] != r_tx_rptr[AW]) && (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[AW] != r_rx_rptr[AW]) && (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);
  assign w_tx_busy  = (r_tx_state == T_SEND);

  assign w_wr_fire = s_awvalid & s_wvalid & !r_bvalid;
  assign w_wr_tx   = w_wr_fire && (s_awaddr[3:2] == 2'd0) && s_wstrb[0];
  assign w_tx_push = w_wr_tx && !w_tx_full;
  assign w_wr_ctrl = w_wr_fire && (s_awaddr[3:2] == 2'd3) && s_wstrb[0];
  assign w_ovr_clr = w_wr_ctrl && s_wdata[4];

  assign w_rd_fire = s_arvalid & !r_rvalid;
  assign w_rx_pop  = w_rd_fire && (s_araddr[3:2] == 2'd1) && !w_rx_empty;
  assign w_rx_rise = new_rx & !r_new_rx_q;
  // A full RX FIFO still accepts the byte when a read frees a slot this cycle.
  assign w_rx_push = w_rx_rise && (!w_rx_full || w_rx_pop);
  assign w_tx_done_rise = tx_done & !r_tx_done_q;

  assign s_awready = !r_bvalid;
  assign s_wready  = !r_bvalid;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_arready = !r_rvalid;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = 2'b00;
  assign data_send = r_data_send;
  assign ena_tx    = r_ena_tx;
  assign w_unused  = ^{s_awaddr[1:0], s_araddr[1:0], s_wdata, s_wstrb};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else if (w_wr_fire) begin
      r_bvalid <= 1'b1;
      r_bresp  <= (w_wr_tx && w_tx_full) ? 2'b10 : 2'b00;
    end else if (s_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  always_comb begin
    w_rdata_nx = 32'd0;
    case (s_araddr[3:2])
      2'd1: w_rdata_nx = w_rx_empty ? 32'h8000_0000 : {24'd0, r_rx_mem[r_rx_rptr[AW-1:0]]};
      2'd2: w_rdata_nx = {26'd0, w_tx_busy, r_overrun, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
      2'd3: w_rdata_nx = {30'd0, w_ctrl};
      default: w_rdata_nx = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
    end else if (w_rd_fire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdata_nx;
    end else if (s_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[AW-1:0]] <= s_wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wptr[AW-1:0]] <= data_recv;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_ONE;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_ONE;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_ONE;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PTR_ONE;
      if (w_rx_rise && w_rx_full && !w_rx_pop) r_overrun <= 1'b1;
      else if (w_ovr_clr)                      r_overrun <= 1'b0;
    end
  end

  // Edge-detector history resets high so a level already high at release is not an edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tx_state  <= T_IDLE;
      r_data_send <= 8'd0;
      r_ena_tx    <= 1'b0;
      r_tx_done_q <= 1'b1;
      r_new_rx_q  <= 1'b1;
    end else begin
      r_tx_state  <= w_tx_state_nx;
      r_data_send <= w_data_send_nx;
      r_ena_tx    <= w_ena_tx_nx;
      r_tx_done_q <= tx_done;
      r_new_rx_q  <= new_rx;
    end
  end

  always_comb begin
    w_tx_state_nx  = r_tx_state;
    w_data_send_nx = r_data_send;
    w_ena_tx_nx    = r_ena_tx;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        if (!w_tx_empty) begin
          w_data_send_nx = r_tx_mem[r_tx_rptr[AW-1:0]];
          w_ena_tx_nx    = 1'b1;
          w_tx_state_nx  = T_SEND;
        end
      end
      T_SEND: begin
        if (w_tx_done_rise) begin
          w_tx_pop      = 1'b1;
          w_ena_tx_nx   = 1'b0;
          w_tx_state_nx = T_IDLE;
        end
      end
    endcase
  end

`ifdef AXI_UART_IRQ_EN
  logic [1:0] r_ctrl;
  logic       r_irq;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ctrl <= 2'b00;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= s_wdata[1:0];
      r_irq <= (r_ctrl[0] & !w_rx_empty) | (r_ctrl[1] & w_tx_empty & !w_tx_busy) | r_overrun;
    end
  end

  assign w_ctrl = r_ctrl;
  assign irq    = r_irq;
`else
  assign w_ctrl = 2'b00;
  assign irq    = 1'b0;
`endif

endmodule

// File: doc/axi_uart_regs.md
# axi_uart_regs

AXI4-Lite responder exposing the UART byte core to a bus master through TX/RX FIFOs and a small register map. Sits between the system interconnect and the UART core's byte port (data_send/ena_tx/tx_done, data_recv/new_rx). It converts single-beat register accesses into one-byte-per-frame transmit requests and captures received bytes. An optional level interrupt is also provided.

## Interface
- FIFO_DEPTH, 16, entries per TX and per RX FIFO; power of two, ≥2
- clk  in  1  clock
- nrst  in  1  reset: nrst, asynchronous, active-low; clock clk
- s_awaddr  in  4  write address, byte address, bits [1:0] ignored
- s_awvalid / s_awready  in / out  1  write address handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_wvalid / s_wready  in / out  1  write data handshake
- s_bresp  out  2  write response
- s_bvalid / s_bready  out / in  1  response handshake
- s_araddr  in  4  read address
- s_arvalid / s_arready  in / out  1  read address handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response, always OKAY
- s_rvalid / s_rready  out / in  1  read data handshake
- data_send  out  8  byte to UART core
- ena_tx  out  1  transmit request to UART core
- tx_done  in  1  UART frame-complete level; high for about one bit period
- data_recv  in  8  received byte from UART core
- new_rx  in  1  UART byte-ready level; high for about one bit period
- irq  out  1  level interrupt

## Operation
- Register map:
  - 0x0 TXDATA, W: wdata[7:0] pushed to TX FIFO.
  - 0x4 RXDATA, R: [7:0] is the head byte; [31]=1 if the FIFO was empty, in which case [7:0]=0. An accepted read pops when the FIFO is non-empty.
  - 0x8 STATUS, R: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] rx_overrun (sticky), [5] tx_busy.
  - 0xC CTRL, RW: [0] rx_irq_en, [1] txe_irq_en; writing 1 to [4] clears rx_overrun (self-clearing).
- Write channel:
  - AW and W are accepted together: s_awready = s_wready = !s_bvalid, and a write completes only when both valids are high.
  - A TXDATA write with wstrb[0]=0 is ignored and returns OKAY.
  - A TXDATA write while tx_full drops the byte and returns SLVERR (2'b10).
  - Writes to RXDATA, STATUS, or unmapped addresses are ignored and return OKAY.
- Read channel: s_arready = !s_rvalid; s_rdata is registered; unmapped addresses read 0.
- TX FSM, edge detector on tx_done:
  - T_IDLE: if the TX FIFO is non-empty, register the head into data_send, set ena_tx=1, and go to T_SEND.
  - T_SEND: hold data_send and ena_tx stable. On a tx_done rising edge, pop the FIFO, set ena_tx=0, and go to T_IDLE.
  - tx_busy = (state==T_SEND).
- RX path:
  - A new_rx rising edge pushes data_recv into the RX FIFO.
  - If the FIFO is full and there is no same-cycle pop, the byte is dropped and rx_overrun is set.
  - A simultaneous push and pop when full both occur, with no overrun.
- FIFOs: circular buffers with pointers one bit wider than log2(FIFO_DEPTH). Full is when the MSBs differ and the rest are equal; pointers wrap naturally.
- TX FIFO push/pop in the same cycle: full is evaluated on pre-cycle state, so a write seen while full is rejected even if a pop occurs that cycle.

## Timing
- Reset values:
  - awready=wready=arready=1.
  - bvalid=rvalid=0; bresp=rdata=0.
  - data_send=0, ena_tx=0, irq=0.
  - FIFOs empty, CTRL=0, overrun=0, FSM in T_IDLE, edge detectors' history=1 (no false edge at reset release).
- Write accepted at cycle N: bvalid at N+1, held until bready; the FIFO push is visible to a STATUS read accepted at N+1.
- Read accepted at N: rvalid/rdata at N+1, held until rready; RXDATA pop occurs at N.
- TX FIFO non-empty at N in T_IDLE: ena_tx=1 and data_send valid at N+1.
- tx_done rising at N: ena_tx=0 at N+1. The next byte's ena_tx=1 comes at N+2 at the earliest.
- new_rx rising at N: byte readable by a read accepted at N+1.
- Reset mid-frame: the FIFOs flush and ena_tx drops immediately; a frame already started by the UART core is not recalled.

## Configuration
- AXI_UART_IRQ_EN defined:
  - irq = (rx_irq_en & !rx_empty) | (txe_irq_en & tx_empty & !tx_busy) | rx_overrun, registered (1-cycle latency).
  - CTRL[1:0] are implemented.
- Not defined: irq is tied to 0; CTRL[1:0] read 0 and writes to them are ignored; bit 4 still clears overrun.

## Test plan
- Write 0x55 then 0xA3 to TXDATA with tx_done pulsed after each ena_tx -> data_send shows 0x55 then 0xA3; one ena_tx assertion per byte; STATUS then reads tx_empty=1, tx_busy=0.
- Write 17 bytes with no tx_done (FIFO_DEPTH=16) -> first 16 return OKAY, the 17th returns bresp=2'b10; STATUS[0]=1.
- Drive 3 new_rx rising edges with data_recv=0x11,0x22,0x33 -> three RXDATA reads return 0x11, 0x22, 0x33; a fourth read returns 0x80000000.
- Drive 17 new_rx edges without reads -> STATUS[4]=1 and the 16 oldest bytes are retained; writing 0x10 to CTRL clears the bit.
- With AXI_UART_IRQ_EN, CTRL=1, one byte received -> irq=1 two cycles after the new_rx edge; irq=0 after the RXDATA read completes.
- Assert nrst mid-T_SEND with 5 bytes queued -> ena_tx=0 immediately; STATUS reads tx_empty=1, rx_empty=1 after release.
